arb_mux: RTL and testbench

//  - N-input, parametrised stream multiplexer for the processor datapath (operand/writeback source select).
//  - Each input is a valid/ready stream. Selection is either round-robin or forced by an external select.
//  - The winning beat is registered into a one-entry output stage, tagged with its source index.
//  - Replaces fixed 2/4/5-input combinational muxes wherever back-pressure or fair sharing is needed.

---
 rtl/arb_mux_pkg.sv | 35 +++
 rtl/arb_mux_rr_arbiter.sv | 26 ++
 rtl/arb_mux.sv | 133 +++++++++++++
 tb/tb_arb_mux.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared limits and channel-index helpers for the arb_mux stream multiplexer.
package arb_mux_pkg;

  localparam int ARB_MUX_MAX_IN = 16;
  localparam int ARB_MUX_IDX_W  = 4;

  function automatic logic [ARB_MUX_IDX_W-1:0] rr_next(
    input logic [ARB_MUX_IDX_W-1:0] idx,
    input logic [ARB_MUX_IDX_W:0]   n
  );
    logic [ARB_MUX_IDX_W-1:0] nxt;
    if ({1'b0, idx} >= (n - 5'd1)) begin
      nxt = 4'd0;
    end else begin
      nxt = idx + 4'd1;
    end
    return nxt;
  endfunction

  function automatic logic [ARB_MUX_IDX_W-1:0] onehot_to_idx(
    input logic [ARB_MUX_MAX_IN-1:0] oh
  );
    logic [ARB_MUX_IDX_W-1:0] idx;
    idx = 4'd0;
    for (int i = 0; i < ARB_MUX_MAX_IN; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder; the first request at or after ptr wins,
// wrapping from NUM_IN-1 back to 0. ptr must be below NUM_IN.
module rr_arbiter #(
  parameter int NUM_IN = 5,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant
);

  logic [2*NUM_IN-1:0] dbl_req_s;
  logic [2*NUM_IN-1:0] dbl_gnt_s;
  logic [NUM_IN-1:0]   rot_req_s;
  logic [NUM_IN-1:0]   rot_gnt_s;
  logic                unused_half_s;

  // Rotate so bit 0 is channel ptr, isolate the lowest set bit, rotate back.
  assign dbl_req_s     = {req, req} >> ptr;
  assign rot_req_s     = dbl_req_s[NUM_IN-1:0];
  assign rot_gnt_s     = rot_req_s & (~rot_req_s + {{(NUM_IN-1){1'b0}}, 1'b1});
  assign dbl_gnt_s     = {rot_gnt_s, rot_gnt_s} << ptr;
  assign grant         = dbl_gnt_s[2*NUM_IN-1:NUM_IN];
  assign unused_half_s = ^{dbl_req_s[2*NUM_IN-1:NUM_IN], dbl_gnt_s[NUM_IN-1:0]};

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-input valid/ready stream mux with round-robin or forced selection and a one-entry
// registered output stage tagged with its source. Optional packet lock: ARB_MUX_PKT_LOCK_EN.
module arb_mux #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 5,
  parameter int SEL_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
`ifdef ARB_MUX_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]            in_last,
  output logic                         out_last,
`endif
  output logic [NUM_IN-1:0]            in_ready,
  input  logic                         force_en,
  input  logic [SEL_W-1:0]             force_sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  import arb_mux_pkg::*;

  logic [SEL_W-1:0]      rr_ptr_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0]      out_sel_r;
  logic                  out_valid_r;

  logic [NUM_IN-1:0]     rr_grant_s;
  logic [NUM_IN-1:0]     forced_oh_s;
  logic [NUM_IN-1:0]     base_grant_s;
  logic [NUM_IN-1:0]     grant_s;
  logic [NUM_IN-1:0]     in_ready_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [SEL_W-1:0]      grant_idx_s;
  logic [SEL_W-1:0]      ptr_next_s;
  logic                  load_s;
  logic                  accept_s;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr_r),
    .grant (rr_grant_s)
  );

  // Base grant: decoded forced channel (out-of-range index decodes to nothing) or round-robin.
  always_comb begin
    forced_oh_s  = '0;
    base_grant_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      forced_oh_s[i] = in_valid[i] && (force_sel == SEL_W'(i));
    end
    if (force_en) begin
      base_grant_s = forced_oh_s;
    end else begin
      base_grant_s = rr_grant_s;
    end
  end

`ifdef ARB_MUX_PKT_LOCK_EN
  logic [NUM_IN-1:0] lock_oh_r;
  logic              out_last_r;

  // An open packet pins the grant to its channel regardless of mode or force_sel.
  assign grant_s = (|lock_oh_r) ? (lock_oh_r & in_valid) : base_grant_s;

  // Packet lock and last-flag register: open on a non-last beat, close on the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_oh_r  <= '0;
      out_last_r <= 1'b0;
    end else if (accept_s) begin
      lock_oh_r  <= (|(grant_s & in_last)) ? '0 : grant_s;
      out_last_r <= |(grant_s & in_last);
    end
  end

  assign out_last = out_last_r;
`else
  assign grant_s = base_grant_s;
`endif

  assign load_s     = !out_valid_r || out_ready;
  assign in_ready_s = (load_s && !reset) ? grant_s : '0;
  assign accept_s   = |in_ready_s;
  assign in_ready   = in_ready_s;

  // Data of the granted channel via one-hot AND-OR.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data_s = sel_data_s | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
    end
  end

  assign grant_idx_s = SEL_W'(onehot_to_idx(ARB_MUX_MAX_IN'(grant_s)));
  assign ptr_next_s  = SEL_W'(rr_next(ARB_MUX_IDX_W'(grant_idx_s), 5'(NUM_IN)));

  // Round-robin pointer: advances past the winner only for round-robin accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (accept_s && !force_en) begin
      rr_ptr_r <= ptr_next_s;
    end
  end

  // Output stage: load a granted beat, or drain when popped with nothing granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
    end else if (load_s) begin
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_data_r <= sel_data_s;
        out_sel_r  <= grant_idx_s;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed and randomized checks of arb_mux against a queue-free behavioural model.
`timescale 1ns/1ps
module tb_arb_mux;

  localparam int DW = 16;
  localparam int N  = 5;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            force_en;
  logic [SW-1:0]   force_sel;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;
`ifdef ARB_MUX_PKT_LOCK_EN
  logic [N-1:0]    in_last;
  logic            out_last;
`endif

  logic [DW-1:0] ch_data [N];
  int tests_run    = 0;
  int tests_failed = 0;

  bit          m_valid;
  logic [DW-1:0] m_data;
  int          m_sel;
  int          m_ptr;
  int          m_lock;
  bit          m_last;

  arb_mux #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef ARB_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = ch_data[i];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit vbit(input logic [N-1:0] v, input int c);
    return v[c[SW-1:0]];
  endfunction

  // Reference grant from the rules: lock, then forced channel, then first valid from pointer.
  function automatic int model_grant();
    int fs;
    if (m_lock >= 0) return vbit(in_valid, m_lock) ? m_lock : -1;
    if (force_en) begin
      fs = int'(force_sel);
      if (fs < N && vbit(in_valid, fs)) return fs;
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (vbit(in_valid, c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (!reset && (!m_valid || out_ready) && g >= 0) r[g[SW-1:0]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = -1; m_last = 1'b0;
  endtask

  // Advance one clock; model follows the same edge. Returns the accepted channel or -1.
  task automatic tick(output int acc);
    int g;
    bit ld;
    g  = model_grant();
    ld = !m_valid || out_ready;
    acc = -1;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        acc = g;
        m_valid = 1'b1;
        m_data  = ch_data[g[SW-1:0]];
        m_sel   = g;
        if (!force_en) m_ptr = (g + 1) % N;
`ifdef ARB_MUX_PKT_LOCK_EN
        m_last = vbit(in_last, g);
        m_lock = m_last ? -1 : g;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int acc;
    for (int c = 0; c < N; c++) ch_data[c] = 16'(16'hA000 + c);
    in_valid = '1; out_ready = 1'b1; force_en = 1'b0; force_sel = '0;
`ifdef ARB_MUX_PKT_LOCK_EN
    in_last = '1;
`endif
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (in_ready !== 5'b00000) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 00000", in_ready);
    end
    tests_run++;
    if ({out_valid, out_sel, out_data} !== {1'b0, 3'd0, 16'h0000}) begin
      tests_failed++; $display("FAIL reset_out: valid=%b sel=%0d data=%h expected 0/0/0", out_valid, out_sel, out_data);
    end
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (in_ready !== 5'b00001) begin
      tests_failed++; $display("FAIL first_ready: got %b expected 00001", in_ready);
    end
    tick(acc);
    tests_run++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 3'd0, 16'hA000}) begin
      tests_failed++; $display("FAIL first_beat: valid=%b sel=%0d data=%h expected 1/0/a000", out_valid, out_sel, out_data);
    end
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== 6'b000000) begin
      tests_failed++; $display("FAIL reset_midstream: valid=%b ready=%b expected 0/00000", out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    out_ready = 1'b1;
  endtask

  task automatic test_round_robin();
    int acc;
    apply_reset();
    in_valid = '1; out_ready = 1'b1; force_en = 1'b0;
    for (int c = 0; c < N; c++) ch_data[c] = 16'(c * 256);
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (in_ready !== model_ready()) begin
        tests_failed++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, in_ready, model_ready());
      end
      tick(acc);
      tests_run++;
      if ({out_valid, out_sel, out_data} !== {1'b1, SW'(i % N), m_data}) begin
        tests_failed++;
        $display("FAIL rr_seq[%0d]: valid=%b sel=%0d data=%h expected 1/%0d/%h", i, out_valid, out_sel, out_data, i % N, m_data);
      end
      if (acc >= 0) ch_data[acc[SW-1:0]] = 16'(acc * 256 + i + 1);
    end
  endtask

  task automatic test_wrap();
    int acc;
    apply_reset();
    out_ready = 1'b1; force_en = 1'b0;
    in_valid = 5'b01000; ch_data[3] = 16'h3301;
    #1;
    tick(acc);
    ch_data[3] = 16'h3302;
    #1;
    tests_run++;
    if (in_ready !== 5'b01000) begin
      tests_failed++; $display("FAIL wrap_ready: got %b expected 01000", in_ready);
    end
    tick(acc);
    tests_run++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 3'd3, 16'h3302}) begin
      tests_failed++; $display("FAIL wrap_beat: valid=%b sel=%0d data=%h expected 1/3/3302", out_valid, out_sel, out_data);
    end
    in_valid = 5'b11001;
    #1;
    tests_run++;
    if (in_ready !== 5'b10000) begin
      tests_failed++; $display("FAIL wrap_ptr: got %b expected 10000", in_ready);
    end
    tick(acc);
  endtask

  task automatic test_backpressure();
    int acc;
    logic [DW-1:0] held_data;
    logic [SW-1:0] held_sel;
    apply_reset();
    in_valid = '1; out_ready = 1'b1; force_en = 1'b0;
    for (int c = 0; c < N; c++) ch_data[c] = 16'(16'hB000 + c);
    #1;
    tick(acc);
    held_data = 16'hB000; held_sel = 3'd0;
    ch_data[0] = 16'hB100;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 5'b00000) begin
        tests_failed++; $display("FAIL bp_ready[%0d]: got %b expected 00000", i, in_ready);
      end
      tick(acc);
      tests_run++;
      if ({out_valid, out_sel, out_data} !== {1'b1, held_sel, held_data}) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h expected 1/%0d/%h", i, out_valid, out_sel, out_data, held_sel, held_data);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 5'b00010) begin
      tests_failed++; $display("FAIL bp_release_ready: got %b expected 00010", in_ready);
    end
    tick(acc);
    tests_run++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 3'd1, 16'hB001}) begin
      tests_failed++; $display("FAIL bp_release: valid=%b sel=%0d data=%h expected 1/1/b001", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_force();
    int acc;
    apply_reset();
    in_valid = 5'b00101; out_ready = 1'b1; force_en = 1'b1; force_sel = 3'd2;
    for (int i = 0; i < 3; i++) begin
      ch_data[0] = 16'(16'hC000 + i); ch_data[2] = 16'(16'hC200 + i);
      #1;
      tests_run++;
      if (in_ready !== 5'b00100) begin
        tests_failed++; $display("FAIL force_ready[%0d]: got %b expected 00100", i, in_ready);
      end
      tick(acc);
      tests_run++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'd2, 16'(16'hC200 + i)}) begin
        tests_failed++; $display("FAIL force_beat[%0d]: valid=%b sel=%0d data=%h", i, out_valid, out_sel, out_data);
      end
    end
    force_sel = 3'd6;
    #1;
    tests_run++;
    if (in_ready !== 5'b00000) begin
      tests_failed++; $display("FAIL force_oob_ready: got %b expected 00000", in_ready);
    end
    tick(acc);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL force_oob_drain: out_valid=%b expected 0", out_valid);
    end
    force_en = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 5'b00001) begin
      tests_failed++; $display("FAIL force_ptr_kept: got %b expected 00001", in_ready);
    end
    tick(acc);
  endtask

  task automatic test_random();
    int acc;
    apply_reset();
    in_valid = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!vbit(in_valid, c) && ($urandom_range(1, 0) == 1)) begin
          in_valid[c[SW-1:0]] = 1'b1;
          ch_data[c[SW-1:0]]  = 16'($urandom);
`ifdef ARB_MUX_PKT_LOCK_EN
          in_last[c[SW-1:0]]  = 1'($urandom_range(1, 0));
`endif
        end
      end
      out_ready = ($urandom_range(3, 0) != 0);
      force_en  = ($urandom_range(4, 0) == 0);
      force_sel = 3'($urandom_range(7, 0));
      #1;
      tests_run++;
      if (in_ready !== model_ready()) begin
        tests_failed++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, model_ready());
      end
      tick(acc);
      tests_run++;
      if ({out_valid, out_sel, out_data} !== {m_valid, SW'(m_sel), m_data}) begin
        tests_failed++;
        $display("FAIL rand_out[%0d]: valid=%b sel=%0d data=%h expected %b/%0d/%h", i, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
`ifdef ARB_MUX_PKT_LOCK_EN
      tests_run++;
      if (out_last !== m_last) begin
        tests_failed++; $display("FAIL rand_last[%0d]: got %b expected %b", i, out_last, m_last);
      end
`endif
      if (acc >= 0) in_valid[acc[SW-1:0]] = 1'b0;
    end
    in_valid = '0;
  endtask

`ifdef ARB_MUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int acc;
    int exp_seq [4] = '{1, 1, 1, 2};
    apply_reset();
    force_en = 1'b0; out_ready = 1'b1;
    in_valid = 5'b00110; in_last = 5'b00100;
    ch_data[1] = 16'hD100; ch_data[2] = 16'hD200;
    for (int b = 0; b < 4; b++) begin
      in_last[1] = (b == 2);
      #1;
      tests_run++;
      if (in_ready !== model_ready()) begin
        tests_failed++; $display("FAIL lock_ready[%0d]: got %b expected %b", b, in_ready, model_ready());
      end
      tick(acc);
      tests_run++;
      if ({out_valid, out_sel, out_last} !== {1'b1, SW'(exp_seq[b]), (b == 2 || b == 3)}) begin
        tests_failed++; $display("FAIL lock_seq[%0d]: valid=%b sel=%0d last=%b expected sel %0d", b, out_valid, out_sel, out_last, exp_seq[b]);
      end
      if (acc == 1) begin
        ch_data[1] = 16'(16'hD101 + b);
        if (b == 2) in_valid[1] = 1'b0;
      end
      if (acc == 2) in_valid[2] = 1'b0;
    end
    apply_reset();
    in_valid = 5'b00010; in_last = 5'b00000;
    #1;
    tick(acc);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, out_last, in_ready} !== 7'b0000000) begin
      tests_failed++; $display("FAIL lock_reset: valid=%b last=%b ready=%b expected all 0", out_valid, out_last, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    in_valid = 5'b00100; in_last = 5'b00100;
    #1;
    tests_run++;
    if (in_ready !== 5'b00100) begin
      tests_failed++; $display("FAIL lock_cleared: got %b expected 00100", in_ready);
    end
    tick(acc);
    tests_run++;
    if ({out_valid, out_sel} !== {1'b1, 3'd2}) begin
      tests_failed++; $display("FAIL lock_after_reset: valid=%b sel=%0d expected 1/2", out_valid, out_sel);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_force();
    test_random();
`ifdef ARB_MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
